ph_ac_collector: RTL and testbench
==================================

Name: ph_ac_collector

Overview:
- Consumer end of the computing cascade's result interface.
- Captures per-channel phase (ph) and amplitude (ac) results as they arrive, tagged by channel address, in any order.
- Once every channel of a frame is present, it moves the set into an output bank and streams it out as one beat per channel, channel 0 first, over a valid/ready handshake.
- Sits between computing_cascade and the host/readout logic.

Parameters:
- CHANELS, 4, number of channels per frame (≥2).
- PH_WIDTH, 32, signed phase width.
- AC_WIDTH, 32, unsigned amplitude width.
- DROP_WIDTH, 16, width of the dropped-frame counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- i_vld  in  1  result strobe from the cascade.
- address  in  $clog2(CHANELS)  channel of the current result.
- ph  in  PH_WIDTH  signed phase result.
- ac  in  AC_WIDTH  amplitude result.
- o_valid  out  1  output beat valid.
- o_ready  in  1  downstream ready.
- o_ch  out  $clog2(CHANELS)  channel index of the current beat.
- o_ph  out  PH_WIDTH  phase of the current beat.
- o_ac  out  AC_WIDTH  amplitude of the current beat.
- o_last  out  1  high on the beat for channel CHANELS-1.
- drop_cnt  out  DROP_WIDTH  saturating count of discarded complete frames.
- busy  out  1  output bank holds an unsent frame.

Behaviour:
- Reset is asynchronous and active-high, single clock domain.
  - On reset: o_valid=0, o_ch=0, o_ph=0, o_ac=0, o_last=0, drop_cnt=0, busy=0.
  - All capture-valid bits clear; FSM returns to IDLE.
  - Reset asserted mid-stream abandons the frame; no further beats are produced.
- Capture bank: CHANELS entries of {ph, ac} plus a per-channel valid bit.
  - On a clk edge with i_vld=1, entry[address] ← {ph, ac} and its valid bit ← 1.
  - A repeat write to an already-valid channel before completion overwrites it (latest wins); no flag is raised.
- Frame completion is the edge where i_vld=1 and every other channel's valid bit is already set.
  - The completing sample is included in the frame.
  - If the output bank is free at that edge: the full set, including the completing sample, is copied into the output bank; all capture valid bits clear; FSM → STREAM.
  - If the output bank is busy: the frame is discarded, valid bits clear, and drop_cnt increments, saturating at all-ones.
  - The output bank counts as free if the FSM is IDLE, or if the last beat handshakes (o_valid & o_ready & o_last) on the same edge.
- FSM states:
  - IDLE: o_valid=0, busy=0.
  - STREAM: o_valid=1, busy=1. Beat index k starts at 0; the beat drives o_ch=k, o_ph/o_ac=bank[k], o_last=(k==CHANELS-1).
  - A handshake (o_valid & o_ready) advances k. On the handshake with o_last=1, go to IDLE, or reload and stay in STREAM with k=0 if a frame completes on the same edge.
- Latency: o_valid rises on the cycle after the completing i_vld edge, with o_ch=0.
- Output stability: while o_valid=1 and o_ready=0, all o_* outputs hold stable. o_valid never drops without a handshake.
- Capture and streaming are independent; captures for the next frame proceed during STREAM.
- Registered outputs: o_* are driven from registers or the output bank, with no combinational path from o_ready to o_valid. o_ph is sign-preserved and no width conversion occurs.
- Addresses ≥ CHANELS (non-power-of-2 CHANELS) are ignored.

Test Plan:
- In-order frame, CHANELS=4: i_vld on addresses 0,1,2,3 with ph=-10,20,-30,40 and ac=1..4, o_ready=1 → o_valid rises one cycle after address 3; 4 consecutive beats with o_ch=0..3, o_ph=-10,20,-30,40, o_ac=1..4; o_last only on beat 3; busy then 0.
- Out-of-order plus overwrite: addresses 2,0,2(ph=99),3,1 → stream fires after address 1; beat 2 shows ph=99; drop_cnt=0.
- Backpressure: o_ready=0 for 5 cycles on beat 1 → o_ch=1 and its data hold; o_valid stays 1; beats resume on o_ready=1.
- Overrun: o_ready=0 while a second full frame completes → drop_cnt=1; after o_ready=1, only the first frame's 4 beats appear. Drive 70000 overruns → drop_cnt saturates at 16'hFFFF.
- Back-to-back boundary: a second frame completes on the same edge as the last-beat handshake → next cycle o_valid=1, o_ch=0 with the new frame data; drop_cnt unchanged.
- Reset mid-stream: assert rst asynchronously during beat 2 → o_valid, busy and o_last drop immediately. After release, a single fresh frame streams correctly and no stale captures appear.

Source files
------------

// File: rtl/ph_ac_collector.sv
// Collects per-channel phase/amplitude results in any order and streams each complete
// frame out over valid/ready, one beat per channel, channel 0 first.
module ph_ac_collector #(
    parameter int CHANELS    = 4,
    parameter int PH_WIDTH   = 32,
    parameter int AC_WIDTH   = 32,
    parameter int DROP_WIDTH = 16,
    localparam int AW = (CHANELS > 1) ? $clog2(CHANELS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_vld,
    input  logic [AW-1:0]              address,
    input  logic signed [PH_WIDTH-1:0] ph,
    input  logic [AC_WIDTH-1:0]        ac,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [AW-1:0]              o_ch,
    output logic signed [PH_WIDTH-1:0] o_ph,
    output logic [AC_WIDTH-1:0]        o_ac,
    output logic                       o_last,
    output logic [DROP_WIDTH-1:0]      drop_cnt,
    output logic                       busy
);

    typedef enum logic {IDLE, STREAM} state_e;

    state_e state_q, state_d;
    logic [AW-1:0] k_q, k_d;

    logic signed [PH_WIDTH-1:0] capPh_q [CHANELS];
    logic [AC_WIDTH-1:0]        capAc_q [CHANELS];
    logic [CHANELS-1:0]         capVld_q;
    logic signed [PH_WIDTH-1:0] bankPh_q [CHANELS];
    logic [AC_WIDTH-1:0]        bankAc_q [CHANELS];
    logic [DROP_WIDTH-1:0]      dropCnt_q;

    logic wr, complete, lastBeat, hs, lastHs, bankFree, load;
    logic [CHANELS-1:0] wrMask;

    assign wr       = i_vld && (32'(address) < 32'(CHANELS));
    assign complete = wr && (&(capVld_q | wrMask));
    assign lastBeat = (k_q == AW'(CHANELS - 1));
    assign hs       = (state_q == STREAM) && o_ready;
    assign lastHs   = hs && lastBeat;
    // The bank is reusable on the very edge its final beat is accepted.
    assign bankFree = (state_q == IDLE) || lastHs;
    assign load     = complete && bankFree;

    always_comb begin
        wrMask = '0;
        if (wr) wrMask[address] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            capVld_q <= '0;
            for (int i = 0; i < CHANELS; i++) begin
                capPh_q[i] <= '0;
                capAc_q[i] <= '0;
            end
        end else begin
            if (wr) begin
                capPh_q[address] <= ph;
                capAc_q[address] <= ac;
            end
            if (complete) capVld_q <= '0;
            else          capVld_q <= capVld_q | wrMask;
        end
    end

    // The completing sample bypasses the capture bank straight into the output bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANELS; i++) begin
                bankPh_q[i] <= '0;
                bankAc_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < CHANELS; i++) begin
                bankPh_q[i] <= wrMask[i] ? ph : capPh_q[i];
                bankAc_q[i] <= wrMask[i] ? ac : capAc_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        dropCnt_q <= '0;
        else if (complete && !bankFree && dropCnt_q != '1) dropCnt_q <= dropCnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = STREAM;
                    k_d     = '0;
                end
            end
            STREAM: begin
                if (hs) begin
                    if (lastBeat) begin
                        k_d = '0;
                        if (!load) state_d = IDLE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    always_comb begin
        o_valid = (state_q == STREAM);
        busy    = (state_q == STREAM);
        o_last  = (state_q == STREAM) && lastBeat;
    end

    assign o_ch     = k_q;
    assign o_ph     = bankPh_q[k_q];
    assign o_ac     = bankAc_q[k_q];
    assign drop_cnt = dropCnt_q;

endmodule

// File: tb/tb_ph_ac_collector.sv
// Bench for ph_ac_collector: table vectors, directed corner sequences and random
// traffic checked against a queue-based frame model.
module tb_ph_ac_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        iVld;
    logic [1:0]  address;
    logic [31:0] ph, ac;
    logic        oReady, oValid, oLast, busy;
    logic [1:0]  oCh;
    logic [31:0] oPh, oAc;
    logic [15:0] dropCnt;

    logic        v2, r2, ov2, ol2, busy2;
    logic [0:0]  a2, och2;
    logic [31:0] p2, c2, oph2, oac2;
    logic [3:0]  dc2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ph_ac_collector dut (
        .clk(clk), .rst(rst), .i_vld(iVld), .address(address), .ph(ph), .ac(ac),
        .o_valid(oValid), .o_ready(oReady), .o_ch(oCh), .o_ph(oPh), .o_ac(oAc),
        .o_last(oLast), .drop_cnt(dropCnt), .busy(busy)
    );

    ph_ac_collector #(.CHANELS(2), .DROP_WIDTH(4)) dut2 (
        .clk(clk), .rst(rst), .i_vld(v2), .address(a2), .ph(p2), .ac(c2),
        .o_valid(ov2), .o_ready(r2), .o_ch(och2), .o_ph(oph2), .o_ac(oac2),
        .o_last(ol2), .drop_cnt(dc2), .busy(busy2)
    );

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] ph;
        logic [31:0] ac;
        logic        last;
    } beat_t;

    typedef struct {
        logic        vld;
        logic [1:0]  addr;
        logic [31:0] ph, ac;
        logic        rdy;
        logic        expValid;
        logic [1:0]  expCh;
        logic [31:0] expPh, expAc;
        logic        expLast, expBusy;
    } vec_t;

    // Model: latest sample per channel, a queue of beats still owed downstream.
    logic [31:0] mPh [4];
    logic [31:0] mAc [4];
    bit          mV  [4];
    beat_t       mQ [$];
    int          mDrop;

    task automatic modelReset();
        mQ.delete();
        for (int i = 0; i < 4; i++) mV[i] = 1'b0;
        mDrop = 0;
    endtask

    task automatic modelStep(input logic v, input logic [1:0] a, input logic [31:0] p,
                             input logic [31:0] c, input logic r);
        bit all;
        beat_t b;
        if (mQ.size() > 0 && r) void'(mQ.pop_front());
        if (v) begin
            mPh[a] = p;
            mAc[a] = c;
            mV[a]  = 1'b1;
            all = mV[0] && mV[1] && mV[2] && mV[3];
            if (all) begin
                if (mQ.size() == 0) begin
                    for (int i = 0; i < 4; i++) begin
                        b.ch = 2'(i); b.ph = mPh[i]; b.ac = mAc[i]; b.last = (i == 3);
                        mQ.push_back(b);
                    end
                end else if (mDrop < 65535) begin
                    mDrop++;
                end
                for (int i = 0; i < 4; i++) mV[i] = 1'b0;
            end
        end
    endtask

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("valid", 64'(oValid), 64'(mQ.size() > 0));
        checkVal("busy", 64'(busy), 64'(mQ.size() > 0));
        checkVal("drop", 64'(dropCnt), 64'(mDrop));
        if (mQ.size() > 0) begin
            checkVal("ch", 64'(oCh), 64'(mQ[0].ch));
            checkVal("ph", 64'(oPh), 64'(mQ[0].ph));
            checkVal("ac", 64'(oAc), 64'(mQ[0].ac));
            checkVal("last", 64'(oLast), 64'(mQ[0].last));
        end else begin
            checkVal("last_idle", 64'(oLast), 64'd0);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] a, input logic [31:0] p,
                                 input logic [31:0] c, input logic r, input bit doCheck);
        @(negedge clk);
        iVld = v; address = a; ph = p; ac = c; oReady = r;
        @(posedge clk);
        modelStep(v, a, p, c, r);
        #1;
        if (doCheck) checkOutput();
    endtask

    task automatic stim2(input logic v, input logic [0:0] a);
        @(negedge clk);
        v2 = v; a2 = a; p2 = $urandom; c2 = $urandom;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic v, logic [1:0] a, logic [31:0] p, logic [31:0] c, logic r,
                                logic ev, logic [1:0] ech, logic [31:0] eph, logic [31:0] eac,
                                logic el, logic eb);
        vec_t t;
        t.vld = v; t.addr = a; t.ph = p; t.ac = c; t.rdy = r;
        t.expValid = ev; t.expCh = ech; t.expPh = eph; t.expAc = eac;
        t.expLast = el; t.expBusy = eb;
        return t;
    endfunction

    initial begin
        vec_t        tbl [8];
        logic [31:0] fa [4];
        logic [31:0] fb [4];

        tbl[0] = mk(1, 0, -32'sd10, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[1] = mk(1, 1,  32'sd20, 2, 1, 0, 0, 0, 0, 0, 0);
        tbl[2] = mk(1, 2, -32'sd30, 3, 1, 0, 0, 0, 0, 0, 0);
        tbl[3] = mk(1, 3,  32'sd40, 4, 1, 1, 0, -32'sd10, 1, 0, 1);
        tbl[4] = mk(0, 0, 0, 0, 1, 1, 1,  32'sd20, 2, 0, 1);
        tbl[5] = mk(0, 0, 0, 0, 1, 1, 2, -32'sd30, 3, 0, 1);
        tbl[6] = mk(0, 0, 0, 0, 1, 1, 3,  32'sd40, 4, 1, 1);
        tbl[7] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        rst = 1'b1; iVld = 0; address = 0; ph = 0; ac = 0; oReady = 0;
        v2 = 0; a2 = 0; p2 = 0; c2 = 0; r2 = 0;
        modelReset();
        #23;
        checkVal("rst_valid", 64'(oValid), 0);
        checkVal("rst_ch", 64'(oCh), 0);
        checkVal("rst_ph", 64'(oPh), 0);
        checkVal("rst_ac", 64'(oAc), 0);
        checkVal("rst_last", 64'(oLast), 0);
        checkVal("rst_drop", 64'(dropCnt), 0);
        checkVal("rst_busy", 64'(busy), 0);
        @(negedge clk);
        rst = 1'b0;

        // In-order frame from the table
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].vld, tbl[i].addr, tbl[i].ph, tbl[i].ac, tbl[i].rdy, 0);
            checkVal($sformatf("tbl%0d_valid", i), 64'(oValid), 64'(tbl[i].expValid));
            checkVal($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].expBusy));
            checkVal($sformatf("tbl%0d_last", i), 64'(oLast), 64'(tbl[i].expLast));
            if (tbl[i].expValid) begin
                checkVal($sformatf("tbl%0d_ch", i), 64'(oCh), 64'(tbl[i].expCh));
                checkVal($sformatf("tbl%0d_ph", i), 64'(oPh), 64'(tbl[i].expPh));
                checkVal($sformatf("tbl%0d_ac", i), 64'(oAc), 64'(tbl[i].expAc));
            end
        end

        // Out-of-order arrival with an overwrite of channel 2
        applyStimulus(1, 2, 32'd7, 32'd70, 1, 1);
        applyStimulus(1, 0, 32'd5, 32'd50, 1, 1);
        applyStimulus(1, 2, 32'd99, 32'd90, 1, 1);
        applyStimulus(1, 3, 32'd8, 32'd80, 1, 1);
        checkVal("ooo_not_yet", 64'(oValid), 0);
        applyStimulus(1, 1, 32'd6, 32'd60, 1, 1);
        checkVal("ooo_fire", 64'(oValid), 1);
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkVal("ooo_ch2", 64'(oCh), 2);
        checkVal("ooo_ph2", 64'(oPh), 99);
        checkVal("ooo_drop", 64'(dropCnt), 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 1);

        // Backpressure on beat 1
        for (int i = 0; i < 4; i++) applyStimulus(1, 2'(i), $urandom, $urandom, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1);
            checkVal("bp_hold_ch", 64'(oCh), 1);
            checkVal("bp_hold_valid", 64'(oValid), 1);
        end
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 1);

        // Overrun: second frame completes while the first is still held
        for (int i = 0; i < 4; i++) begin
            fa[i] = $urandom;
            applyStimulus(1, 2'(i), fa[i], $urandom, 0, 1);
        end
        for (int i = 0; i < 4; i++) applyStimulus(1, 2'(i), $urandom, $urandom, 0, 1);
        checkVal("overrun_drop", 64'(dropCnt), 1);
        checkVal("overrun_ph0", 64'(oPh), 64'(fa[0]));
        for (int i = 1; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 1);
            checkVal($sformatf("overrun_ph%0d", i), 64'(oPh), 64'(fa[i]));
        end
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkVal("overrun_idle", 64'(oValid), 0);
        applyStimulus(0, 0, 0, 0, 1, 1);

        // Back-to-back: next frame completes on the last-beat handshake
        for (int i = 0; i < 4; i++) applyStimulus(1, 2'(i), $urandom, $urandom, 1, 1);
        for (int i = 0; i < 4; i++) begin
            fb[i] = $urandom;
            applyStimulus(1, 2'(i), fb[i], $urandom, 1, 1);
        end
        checkVal("b2b_valid", 64'(oValid), 1);
        checkVal("b2b_ch", 64'(oCh), 0);
        checkVal("b2b_ph", 64'(oPh), 64'(fb[0]));
        checkVal("b2b_drop", 64'(dropCnt), 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1, 1);

        // Reset during beat 2 with a partial next frame captured
        for (int i = 0; i < 4; i++) applyStimulus(1, 2'(i), $urandom, $urandom, 1, 1);
        applyStimulus(1, 0, $urandom, $urandom, 1, 1);
        applyStimulus(1, 1, $urandom, $urandom, 1, 1);
        checkVal("rst_mid_pre_ch", 64'(oCh), 2);
        #2;
        iVld = 1'b0;
        rst = 1'b1;
        #1;
        checkVal("rst_mid_valid", 64'(oValid), 0);
        checkVal("rst_mid_busy", 64'(busy), 0);
        checkVal("rst_mid_last", 64'(oLast), 0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 2, $urandom, $urandom, 1, 1);
        applyStimulus(1, 3, $urandom, $urandom, 1, 1);
        checkVal("rst_no_stale", 64'(oValid), 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 2'(i), $urandom, $urandom, 1, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1, 1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom,
                          $urandom_range(0, 9) < 7, 1);
        end

        // Drop counter saturation on a narrow two-channel instance
        iVld = 1'b0;
        r2 = 1'b0;
        for (int f = 0; f <= 20; f++) begin
            stim2(1, 0);
            stim2(1, 1);
            checkVal($sformatf("sat_drop%0d", f), 64'(dc2), 64'((f > 15) ? 15 : f));
        end
        v2 = 1'b0;
        checkVal("sat_valid", 64'(ov2), 1);
        checkVal("sat_ch", 64'(och2), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
